rvfi_retire_sequencer: RTL

- Sits between the pipeline retire sources and the RVFI trace monitor.
- Merges two retirement requesters into one in-order retire stream:
  - s0: main pipeline writeback.
  - s1: trap/exception injector.
- Path: round-robin arbiter, then FIFO, then one packet per cycle to the monitor over a valid/ready handshake, with a 64-bit order tag.
- Also sequences halt (drain, then stop) and flush (discard queued retirements).

---
 rtl/rvfi_seq_pkg.sv | 20 ++
 rtl/rvfi_seq_fifo.sv | 74 +++++++
 rtl/rvfi_retire_sequencer.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/rvfi_seq_pkg.sv
// Shared definitions for the RVFI retire sequencer: packet field offsets,
// source ids and sequencer state encoding.
package rvfi_seq_pkg;

  localparam int unsigned INSN_LSB     = 64;
  localparam int unsigned PC_RDATA_LSB = 32;
  localparam int unsigned PC_WDATA_LSB = 0;

  localparam int unsigned ORDER_W = 64;

  localparam logic SRC_PIPE = 1'b0;
  localparam logic SRC_TRAP = 1'b1;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    HALTED
  } seq_state_e;

endpackage

// File: rtl/rvfi_seq_fifo.sv
// Retire FIFO: registered storage of {order, src, pkt} entries with wrapping
// pointers, occupancy count and a flush that discards everything queued.
module rvfi_seq_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 161,
  parameter int unsigned CNT_W = 3
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [W-1:0]     wdata,
  output logic [W-1:0]     rdata,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [W-1:0]     mem_q [DEPTH];
  logic [W-1:0]     mem_d [DEPTH];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = wdata;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;
  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));

endmodule

// File: rtl/rvfi_retire_sequencer.sv
// Merges pipeline and trap retirements into one ordered RVFI stream with
// halt/flush sequencing. Define RVFI_RETIRE_SEQ_PERF_EN for stall/high-water counters.
module rvfi_retire_sequencer
  import rvfi_seq_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PKT_W = 96,
  parameter int unsigned CNT_W = 3
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               s0_valid,
  output logic               s0_ready,
  input  logic [PKT_W-1:0]   s0_pkt,
  input  logic               s1_valid,
  output logic               s1_ready,
  input  logic [PKT_W-1:0]   s1_pkt,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [PKT_W-1:0]   m_pkt,
  output logic               m_src,
  output logic [63:0]        m_order,
  input  logic               halt_req,
  output logic               halted,
  input  logic               flush,
  output logic [CNT_W-1:0]   count,
  output logic               overflow
`ifdef RVFI_RETIRE_SEQ_PERF_EN
  ,
  output logic [31:0]        stall_cycles,
  output logic [CNT_W-1:0]   max_count
`endif
);

  localparam int unsigned ENT_W = ORDER_W + 1 + PKT_W;

  seq_state_e         state_q, state_d;
  logic               last_grant_q, last_grant_d;
  logic [ORDER_W-1:0] order_q, order_d;
  logic               overflow_q, overflow_d;
  logic               halted_q, halted_d;

  logic               fifo_empty, fifo_full;
  logic [CNT_W-1:0]   fifo_count;
  logic [ENT_W-1:0]   fifo_rdata, fifo_wdata;
  logic               pop, can_push, grant, pick_trap, push_src;
  logic [PKT_W-1:0]   push_pkt;

  rvfi_seq_fifo #(
    .DEPTH (DEPTH),
    .W     (ENT_W),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (grant),
    .pop     (pop),
    .flush   (flush),
    .wdata   (fifo_wdata),
    .rdata   (fifo_rdata),
    .count   (fifo_count),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

  always_comb begin
    m_valid  = !fifo_empty && (state_q != HALTED);
    pop      = m_valid && m_ready;
    // A full FIFO still accepts when the head leaves in the same cycle.
    can_push = (state_q == RUN) && !flush && (!fifo_full || pop);
    // With both requesting, the source that did not win last time goes.
    pick_trap = s1_valid && (!s0_valid || (last_grant_q == SRC_PIPE));
    grant     = can_push && (s0_valid || s1_valid);
    s0_ready  = grant && !pick_trap;
    s1_ready  = grant && pick_trap;
    push_src  = pick_trap ? SRC_TRAP : SRC_PIPE;
    push_pkt  = pick_trap ? s1_pkt : s0_pkt;
    fifo_wdata = {order_q, push_src, push_pkt};

    last_grant_d = grant ? push_src : last_grant_q;
    order_d      = order_q + ORDER_W'(grant);
    overflow_d   = overflow_q ||
                   ((s0_valid || s1_valid) && fifo_full && !pop && (state_q == RUN));

    state_d = state_q;
    case (state_q)
      RUN:     if (halt_req) state_d = DRAIN;
      DRAIN: begin
        if (fifo_empty)     state_d = HALTED;
        else if (!halt_req) state_d = RUN;
      end
      HALTED:  state_d = HALTED;
      default: state_d = RUN;
    endcase
    halted_d = (state_d == HALTED);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= RUN;
      last_grant_q <= SRC_TRAP;
      order_q      <= '0;
      overflow_q   <= 1'b0;
      halted_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      order_q      <= order_d;
      overflow_q   <= overflow_d;
      halted_q     <= halted_d;
    end
  end

  assign {m_order, m_src, m_pkt} = fifo_rdata;
  assign count    = fifo_count;
  assign overflow = overflow_q;
  assign halted   = halted_q;

`ifdef RVFI_RETIRE_SEQ_PERF_EN
  logic [31:0]      stall_cycles_q, stall_cycles_d;
  logic [CNT_W-1:0] max_count_q, max_count_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (m_valid && !m_ready && (stall_cycles_q != '1)) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
    end
    max_count_d = (fifo_count > max_count_q) ? fifo_count : max_count_q;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stall_cycles_q <= '0;
      max_count_q    <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      max_count_q    <= max_count_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign max_count    = max_count_q;
`endif

endmodule
